// File: rtl/pk_stream_packer.sv
// rtl/pk_stream_packer.sv - serializes rho || polyt1_pack(t1[0..K-1]) as a byte stream
// t1 is fetched four coefficients at a time from a synchronous memory and emitted as five bytes.
module pk_stream_packer #(
  parameter int K      = 6,
  parameter int N      = 256,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [255:0]      rho,
  output logic              busy,
  output logic              done,
  output logic              t1_rd_en,
  output logic [ADDR_W-1:0] t1_rd_addr,
  input  logic [31:0]       t1_rd_data,
  output logic [7:0]        pk_byte,
  output logic              pk_valid,
  input  logic              pk_ready,
  output logic              pk_last
);

  localparam int NGROUPS = K * N / 4;
  localparam int GW      = $clog2(NGROUPS);
  localparam logic [GW-1:0] G_LAST = GW'(NGROUPS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RHO   = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_EMIT  = 2'd3;

  logic [1:0]    state;
  logic [255:0]  rho_q;
  logic [4:0]    cnt;
  logic [GW-1:0] g;
  logic [2:0]    e;
  logic [2:0]    f;
  logic [9:0]    a0, a1, a2, a3;

  logic [4:0]    cnt_nxt;
  logic [2:0]    e_nxt;
  logic [GW-1:0] g_nxt;
  logic [7:0]    emit_nxt;
  logic [9:0]    rd_coeff;
  logic          unused_rd_bits;

  assign cnt_nxt        = cnt + 5'd1;
  assign e_nxt          = e + 3'd1;
  assign g_nxt          = g + GW'(1);
  assign rd_coeff       = t1_rd_data[9:0];
  assign unused_rd_bits = ^t1_rd_data[31:10];

  // Byte e of a group: four 10-bit coefficients laid out LSB-first over 40 bits.
  always_comb begin
    emit_nxt = 8'h00;
    case (e_nxt)
      3'd0:    emit_nxt = a0[7:0];
      3'd1:    emit_nxt = {a1[5:0], a0[9:8]};
      3'd2:    emit_nxt = {a2[3:0], a1[9:6]};
      3'd3:    emit_nxt = {a3[1:0], a2[9:4]};
      3'd4:    emit_nxt = a3[9:2];
      default: emit_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rho_q      <= '0;
      cnt        <= '0;
      g          <= '0;
      e          <= '0;
      f          <= '0;
      a0         <= '0;
      a1         <= '0;
      a2         <= '0;
      a3         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      t1_rd_en   <= 1'b0;
      t1_rd_addr <= '0;
      pk_byte    <= 8'h00;
      pk_valid   <= 1'b0;
      pk_last    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            rho_q    <= rho;
            cnt      <= '0;
            g        <= '0;
            state    <= S_RHO;
            busy     <= 1'b1;
            pk_valid <= 1'b1;
            pk_byte  <= rho[7:0];
            pk_last  <= 1'b0;
          end
        end
        S_RHO: begin
          if (pk_ready) begin
            if (cnt == 5'd31) begin
              state      <= S_FETCH;
              f          <= '0;
              pk_valid   <= 1'b0;
              t1_rd_en   <= 1'b1;
              t1_rd_addr <= '0;
            end else begin
              cnt     <= cnt_nxt;
              pk_byte <= rho_q[{cnt_nxt, 3'b000} +: 8];
            end
          end
        end
        S_FETCH: begin
          // Read data lags the strobe by one cycle, so captures trail addresses by one.
          f <= f + 3'd1;
          case (f)
            3'd0: t1_rd_addr <= t1_rd_addr + ADDR_W'(1);
            3'd1: begin
              a0         <= rd_coeff;
              t1_rd_addr <= t1_rd_addr + ADDR_W'(1);
            end
            3'd2: begin
              a1         <= rd_coeff;
              t1_rd_addr <= t1_rd_addr + ADDR_W'(1);
            end
            3'd3: begin
              a2       <= rd_coeff;
              t1_rd_en <= 1'b0;
            end
            default: begin
              a3       <= rd_coeff;
              state    <= S_EMIT;
              e        <= '0;
              pk_valid <= 1'b1;
              pk_byte  <= a0[7:0];
              pk_last  <= 1'b0;
            end
          endcase
        end
        default: begin
          if (pk_ready) begin
            if (e == 3'd4) begin
              pk_valid <= 1'b0;
              pk_last  <= 1'b0;
              if (g == G_LAST) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                g          <= g_nxt;
                state      <= S_FETCH;
                f          <= '0;
                t1_rd_en   <= 1'b1;
                t1_rd_addr <= ADDR_W'({g_nxt, 2'b00});
              end
            end else begin
              e       <= e_nxt;
              pk_byte <= emit_nxt;
              pk_last <= (g == G_LAST) && (e == 3'd3);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/pk_stream_packer.md
# pk_stream_packer

Sequential public-key packer for Dilithium key generation (K=6). Serializes the public key rho || polyt1_pack(t1[0..K-1]) into a byte stream with valid/ready flow control. It reads t1 coefficients one at a time from a synchronous coefficient memory instead of a 49152-bit bus, so it replaces the wide combinational packer at the key-generation output. Output byte order and values are bit-identical to the linear packed pk: 1952 bytes, 32 of rho, then 6 × 320 of t1.

## Interface
- K, 6, number of t1 polynomials
- N, 256, coefficients per polynomial
- ADDR_W, 11, t1 memory address width (covers K*N = 1536 words)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a pack run; accepted only in IDLE
- rho  in  256  seed; latched on accepted start; byte j = rho[8j+7:8j]
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last byte handshake
- t1_rd_en  out  1  coefficient read strobe
- t1_rd_addr  out  ADDR_W  coefficient address = 256*poly + coeff
- t1_rd_data  in  32  coefficient word, valid the cycle after t1_rd_en; bits [9:0] used, [31:10] ignored
- pk_byte  out  8  output byte
- pk_valid  out  1  pk_byte valid
- pk_ready  in  1  consumer accepts; handshake = pk_valid & pk_ready
- pk_last  out  1  high with byte 1951

## Operation
- FSM states: IDLE, RHO, FETCH, EMIT.
- IDLE:
  - if start is high, latch rho, clear the byte counter and group counter g, and go to RHO.
- RHO:
  - pk_valid=1; pk_byte = rho byte (counter).
  - On each handshake, increment the counter.
  - After the handshake of byte 31, go to FETCH with g=0.
- FETCH (5 cycles, f0..f4):
  - f0..f3: t1_rd_en=1, t1_rd_addr = 4g+k for k=0..3.
  - f1..f4: capture t1_rd_data[9:0] into a[k-1].
  - After f4, go to EMIT.
  - Exactly 4 reads per group; no reads in any other state.
- EMIT (5 bytes, e=0..4), pk_valid=1:
  - b0 = a0[7:0]
  - b1 = {a1[5:0], a0[9:8]}
  - b2 = {a2[3:0], a1[9:6]}
  - b3 = {a3[1:0], a2[9:4]}
  - b4 = a3[9:2]
  - e advances on each handshake.
  - After the handshake of b4: if g=383, go to IDLE and pulse done; otherwise increment g and go to FETCH.
- pk_last = EMIT & g=383 & e=4.
- Stall rule: while pk_valid & !pk_ready, pk_byte, pk_last and all state are held stable.
- pk_valid never drops without a handshake.
- start is ignored while not in IDLE; rho changes after acceptance have no effect.
- A start high in the same cycle as done (FSM already in IDLE) is accepted.

## Timing
- Reset values (async assert, sync-free): FSM=IDLE, busy=0, done=0, pk_valid=0, pk_last=0, pk_byte=0, t1_rd_en=0, t1_rd_addr=0, counters=0.
- Reset mid-run aborts immediately:
  - no done pulse;
  - the partial stream is discarded by the consumer;
  - the next start restarts from byte 0.
- All outputs are registered, with no combinational path from pk_ready to pk_valid.
- Edge numbering: start is sampled at edge 0.
- First byte: pk_valid=1 in the cycle after edge 0.
- Throughput with pk_ready=1:
  - RHO: 32 cycles.
  - Each group: 5 FETCH + 5 EMIT = 10 cycles.
  - 384 groups: 3840 cycles.
- Last handshake at edge 3872; done is high between edges 3872 and 3873.
- Every cycle of pk_ready=0 during RHO/EMIT adds one cycle.
- FETCH duration is independent of pk_ready.

## Test plan
- Basic run: rho bytes 0x00..0x1F, all t1=0, pk_ready=1.
  - Stream is 0x00..0x1F, then 1920 bytes of 0x00.
  - pk_last on byte 1951.
  - done exactly one cycle, between edges 3872 and 3873.
  - Exactly 1536 reads, addresses 0..1535 in order.
- All t1=0x3FF: bytes 32..1951 are all 0xFF.
- Packing and masking: t1[0..3] = 0xFFFFFC01, 0x002, 0x003, 0x004 (upper bits garbage).
  - Bytes 32..36 = 0x01, 0x08, 0x30, 0x00, 0x01.
- Random t1 and rho, pk_ready random at 30% low.
  - Stream matches the software pack_pk golden.
  - pk_byte/pk_last stable during stalls.
  - No extra or missing reads.
- Control edges:
  - start pulses during busy are ignored;
  - rho altered after start does not change the output;
  - start in the done cycle begins a second correct run.
- Reset mid-stream: rst_n low at byte 500.
  - All outputs go to 0 asynchronously.
  - No done pulse.
  - A following start yields a complete correct 1952-byte stream.
